// File: rtl/mpx_scan_if.sv
// mpx_scan_if: channel data, select/mode/enable controls and the registered
// outputs of the mpx_scan multiplexer, bundled for a single port.
interface mpx_scan_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned CH = 4
);
  logic [CH*W-1:0] din;
  logic [CH-1:0]   sel;
  logic            mode;
  logic            en;
  logic [W-1:0]    dout;
  logic [CH-1:0]   act;
  logic            sel_err;
  logic            scan_tick;

  // Stimulus side: drives data and controls, observes the outputs.
  modport master (
    output din, sel, mode, en,
    input  dout, act, sel_err, scan_tick
  );

  // Multiplexer side.
  modport slave (
    input  din, sel, mode, en,
    output dout, act, sel_err, scan_tick
  );
endinterface

// File: rtl/mpx_scan.sv
// mpx_scan: CH-channel, W-bit registered multiplexer with a validated one-hot
// manual select and a prescaled auto-scan rotator (display-digit multiplexing,
// result cycling).
// Build option: define MPX_PRIORITY_EN to resolve a multi-hot manual select to
// its lowest set bit instead of flagging it as illegal.
module mpx_scan #(
  parameter int unsigned W        = 16,
  parameter int unsigned CH       = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  mpx_scan_if.slave   bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [W-1:0]  r_dout;
  logic [CH-1:0] r_act;
  logic          r_sel_err;
  logic          r_scan_tick;
  logic [PW-1:0] r_presc;
  logic          r_mode_q;

  logic          w_manual;
  logic          w_entry;
  logic          w_scan;
  logic          w_wrap;
  logic          w_sel_ok;
  logic [CH-1:0] w_sel_pick;
  logic [CH-1:0] w_act_rot;
  logic [W-1:0]  w_din_act;
  logic [W-1:0]  w_din_sel;

  // Update class for this cycle: manual, first auto cycle, or steady auto-scan.
  assign w_manual = bus.en & ~bus.mode;
  assign w_entry  = bus.en &  bus.mode & ~r_mode_q;
  assign w_scan   = bus.en &  bus.mode &  r_mode_q;
  assign w_wrap   = w_scan & (r_presc == PRESC_LAST);

  assign w_act_rot = {r_act[CH-2:0], r_act[CH-1]};

`ifdef MPX_PRIORITY_EN
  // Isolate the lowest set bit; only an all-zero select is illegal.
  assign w_sel_pick = bus.sel & (~bus.sel + CH'(1));
  assign w_sel_ok   = (bus.sel != '0);
`else
  logic w_sel_multi;

  // Exactly one-hot: nonzero and clearing the lowest set bit leaves nothing.
  assign w_sel_multi = ((bus.sel & (bus.sel - CH'(1))) != '0);
  assign w_sel_pick  = bus.sel;
  assign w_sel_ok    = (bus.sel != '0) && !w_sel_multi;
`endif

  // One-hot AND-OR mux of the channel currently driving the output.
  always_comb begin
    w_din_act = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (r_act[k]) w_din_act = w_din_act | bus.din[k*W +: W];
    end
  end

  // One-hot AND-OR mux of the channel named by the resolved manual select.
  always_comb begin
    w_din_sel = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (w_sel_pick[k]) w_din_sel = w_din_sel | bus.din[k*W +: W];
    end
  end

  // Mode history; the 0->1 edge of mode_q marks the auto-scan entry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_mode_q <= 1'b0;
    else if (bus.en) r_mode_q <= bus.mode;
  end

  // Prescaler counts only during steady auto-scan; cleared otherwise while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_presc <= '0;
    else if (w_manual | w_entry) r_presc <= '0;
    else if (w_wrap)             r_presc <= '0;
    else if (w_scan)             r_presc <= r_presc + PW'(1);
  end

  // Advance pulse, one cycle wide, forced low whenever the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_scan_tick <= 1'b0;
    else if (!bus.en) r_scan_tick <= 1'b0;
    else              r_scan_tick <= w_wrap;
  end

  // Active channel and output data: manual load, entry to channel 0, or rotation.
  // During scan, dout samples the pre-rotation act, so it trails act by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act  <= CH'(1);
      r_dout <= '0;
    end else if (w_manual) begin
      if (w_sel_ok) begin
        r_act  <= w_sel_pick;
        r_dout <= w_din_sel;
      end
    end else if (w_entry) begin
      r_act  <= CH'(1);
      r_dout <= bus.din[W-1:0];
    end else if (w_scan) begin
      r_dout <= w_din_act;
      if (w_wrap) r_act <= w_act_rot;
    end
  end

  // Illegal-select flag, re-evaluated on every enabled cycle, never sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sel_err <= 1'b0;
    else if (bus.en) r_sel_err <= w_manual & ~w_sel_ok;
  end

  assign bus.dout      = r_dout;
  assign bus.act       = r_act;
  assign bus.sel_err   = r_sel_err;
  assign bus.scan_tick = r_scan_tick;

endmodule

// File: tb/tb_mpx_scan.sv
// tb_mpx_scan: randomized and directed stimulus for mpx_scan, checked against
// a channel-index reference model of the multiplexer's rules.
module tb_mpx_scan;

  localparam int unsigned W        = 16;
  localparam int unsigned CH       = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam logic [CH*W-1:0] DEF_DIN = {16'h0004, 16'h0003, 16'h0002, 16'h0001};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpx_scan_if #(.W(W), .CH(CH)) bus ();

  mpx_scan #(.W(W), .CH(CH), .SCAN_DIV(SCAN_DIV)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel index, cycles spent on it, auto-scan active flag.
  int           m_ch;
  int           m_cnt;
  bit           m_auto;
  logic [W-1:0] m_dout;
  logic         m_err;
  logic         m_tick;

  function automatic logic [W-1:0] chan(input logic [CH*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  function automatic logic [W+CH+1:0] exp_vec();
    logic [CH-1:0] a;
    a = '0;
    a[m_ch] = 1'b1;
    return {m_dout, a, m_err, m_tick};
  endfunction

  function automatic logic [W+CH+1:0] obs_vec();
    return {bus.dout, bus.act, bus.sel_err, bus.scan_tick};
  endfunction

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; m_auto = 0; m_dout = '0; m_err = 0; m_tick = 0;
  endtask

  task automatic model_clock();
    int ones;
    int low;
    ones = $countones(bus.sel);
    low  = -1;
    for (int i = 0; i < CH; i++) if (bus.sel[i] && low < 0) low = i;
    if (!bus.en) begin
      m_tick = 0;
    end else if (!bus.mode) begin
      m_auto = 0; m_cnt = 0; m_tick = 0;
`ifdef MPX_PRIORITY_EN
      if (ones >= 1) begin
`else
      if (ones == 1) begin
`endif
        m_ch = low; m_dout = chan(bus.din, low); m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (!m_auto) begin
      m_auto = 1; m_ch = 0; m_cnt = 0; m_dout = chan(bus.din, 0); m_err = 0; m_tick = 0;
    end else begin
      m_dout = chan(bus.din, m_ch);
      m_err  = 0;
      m_cnt  = m_cnt + 1;
      if (m_cnt == SCAN_DIV) begin
        m_cnt = 0; m_ch = (m_ch + 1) % CH; m_tick = 1;
      end else begin
        m_tick = 0;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.din = DEF_DIN;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
    n_checks++; if (bus.act !== 4'b0001) begin n_fail++; $display("FAIL reset_act got=%b exp=0001", bus.act); end
    n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", bus.sel_err); end
    n_checks++; if (bus.scan_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", bus.scan_tick); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual_sweep();
    bus.en = 1'b1; bus.mode = 1'b0;
    for (int k = 0; k < CH; k++) begin
      bus.sel = 4'b0001 << k;
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL manual_sweep k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      n_checks++;
      if (bus.dout !== 16'(k + 1) || bus.sel_err !== 1'b0) begin
        n_fail++; $display("FAIL manual_dout k=%0d got=%h/%b exp=%h/0", k, bus.dout, bus.sel_err, 16'(k + 1));
      end
    end
  endtask

  task automatic test_illegal_sel();
    logic [CH-1:0] pat [3];
    pat[0] = 4'b0100; pat[1] = 4'b0000; pat[2] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      bus.sel = pat[i];
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL illegal_sel i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
`ifdef MPX_PRIORITY_EN
    n_checks++;
    if (bus.dout !== 16'h0002 || bus.act !== 4'b0010 || bus.sel_err !== 1'b0) begin
      n_fail++; $display("FAIL priority_sel got=%h/%b/%b exp=0002/0010/0", bus.dout, bus.act, bus.sel_err);
    end
`else
    n_checks++;
    if (bus.dout !== 16'h0003 || bus.act !== 4'b0100 || bus.sel_err !== 1'b1) begin
      n_fail++; $display("FAIL multi_hot_hold got=%h/%b/%b exp=0003/0100/1", bus.dout, bus.act, bus.sel_err);
    end
`endif
  endtask

  task automatic test_auto_wrap();
    int ticks;
    logic prev;
    ticks = 0; prev = 1'b0;
    bus.sel = 4'b0010; bus.mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL auto_wrap i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if (bus.act !== 4'b0001 || bus.scan_tick !== 1'b0) begin
          n_fail++; $display("FAIL auto_entry got=%b/%b exp=0001/0", bus.act, bus.scan_tick);
        end
      end
      if (bus.scan_tick === 1'b1) ticks++;
      if (prev === 1'b1 && bus.scan_tick === 1'b1) begin
        n_checks++; n_fail++; $display("FAIL tick_width i=%0d got=2+ exp=1", i);
      end
      prev = bus.scan_tick;
    end
    n_checks++;
    if (ticks != 4) begin n_fail++; $display("FAIL tick_count got=%0d exp=4", ticks); end
  endtask

  task automatic test_enable_freeze();
    logic [W+CH+1:0] held;
    int guard;
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin
      cyc(); guard++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL freeze_seek got=%h exp=%h", obs_vec(), exp_vec());
      end
    end
    if (m_cnt != 2) begin n_checks++; n_fail++; $display("FAIL freeze_seek_timeout got=%0d exp=2", m_cnt); end
    held = exp_vec();
    held[0] = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (obs_vec() !== held) begin
        n_fail++; $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, obs_vec(), held);
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.scan_tick !== logic'(i == 1)) begin
        n_fail++; $display("FAIL freeze_resume i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_live_data_exit();
    int guard;
    guard = 0;
    while (!(m_ch == 1 && m_cnt == 0) && guard < 40) begin
      cyc(); guard++;
    end
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.act !== 4'b0010) begin
      n_fail++; $display("FAIL live_seek got=%h exp=%h", obs_vec(), exp_vec());
    end
    bus.din[W +: W] = 16'hBEEF;
    cyc();
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.dout !== 16'hBEEF) begin
      n_fail++; $display("FAIL live_data got=%h exp=%h", obs_vec(), exp_vec());
    end
    bus.mode = 1'b0; bus.sel = 4'b1000;
    cyc();
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.dout !== 16'h0004 || bus.act !== 4'b1000) begin
      n_fail++; $display("FAIL mode_exit got=%h exp=%h", obs_vec(), exp_vec());
    end
    n_checks++;
    if (u_dut.r_presc !== '0) begin n_fail++; $display("FAIL exit_presc got=%0d exp=0", u_dut.r_presc); end
    bus.din = DEF_DIN;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      bus.sel = CH'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus.din = {$urandom, $urandom};
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    bus.din = DEF_DIN;
  endtask

  task automatic test_reset_midscan();
    int guard;
    guard = 0;
    bus.en = 1'b1; bus.mode = 1'b1;
    while (!(m_auto && m_ch == 2) && guard < 60) begin
      cyc(); guard++;
    end
    n_checks++;
    if (bus.act !== 4'b0100) begin n_fail++; $display("FAIL midscan_seek got=%b exp=0100", bus.act); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== {16'h0000, 4'b0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midscan_reset got=%h exp=%h", obs_vec(), {16'h0000, 4'b0001, 1'b0, 1'b0});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midscan_restart i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (bus.scan_tick !== logic'(i == 4) || (i == 0 && bus.act !== 4'b0001)) begin
        n_fail++; $display("FAIL midscan_tick i=%0d got=%b/%b", i, bus.scan_tick, bus.act);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_illegal_sel();
    test_auto_wrap();
    test_enable_freeze();
    test_live_data_exit();
    test_random();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpx_scan.md
Name: mpx_scan

Overview:
- Parametrised successor to the calculator's 4-input one-hot operand/result multiplexer.
- Selects one of CH channels of width W and presents it on a registered output.
- Manual mode: channel chosen by a validated one-hot select.
- Auto-scan mode: an internal prescaled rotator steps through the channels, for display-digit multiplexing and result cycling.

Parameters:
- W, 16, data width per channel
- CH, 4, channel count (2..16)
- SCAN_DIV, 1000, clock cycles per channel in auto-scan mode (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  CH*W  packed channel data; channel k at bits [k*W+W-1 : k*W]
- sel  in  CH  one-hot channel select, used in manual mode only
- mode  in  1  0 = manual, 1 = auto-scan
- en  in  1  update enable; when 0, all state and outputs hold
- dout  out  W  registered selected data
- act  out  CH  one-hot channel currently driving dout
- sel_err  out  1  registered flag: illegal sel in the last manual update
- scan_tick  out  1  one-cycle pulse when auto-scan advances channel

Behaviour:
- Reset (rst_n=0, asynchronous): dout=0, act=1 (channel 0), sel_err=0, scan_tick=0, prescaler=0, mode_q=0.
- Reset release: first update on the first rising clk edge with rst_n=1 and en=1.
- en=0: all registers hold, including the prescaler. scan_tick=0 while en=0.
- Manual mode (mode=1'b0, en=1), one-cycle latency:
  - sel exactly one-hot: act<=sel, dout<=din channel of sel, sel_err<=0.
  - sel=0 or multi-hot: act and dout hold, sel_err<=1.
  - sel_err is re-evaluated every enabled manual cycle, not sticky.
  - Prescaler held at 0; scan_tick=0.
- Auto-scan mode (mode=1, en=1):
  - Prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: prescaler<=0, act rotates left one position, scan_tick<=1 for one cycle.
  - Wrap: act=bit CH-1 rotates to bit 0.
  - dout<=din[act] every enabled cycle, so live data changes on the current channel appear with one-cycle latency.
  - dout follows the new act one cycle after the rotation.
  - sel is ignored; sel_err<=0.
- Mode entry, 0->1 (detected via registered mode_q):
  - On the first auto cycle, act<=1 (channel 0), prescaler<=0, dout<=din channel 0.
  - No scan_tick on the entry cycle.
- Mode exit, 1->0: prescaler<=0. The first manual cycle applies sel normally; an illegal sel holds the last auto-scan act and dout.
- SCAN_DIV=1: rotation every enabled cycle; scan_tick high every auto cycle except the entry cycle.
- Reset mid-scan: immediate return to reset values; auto-scan restarts at channel 0 after release (mode_q=0 forces an entry sequence).
- act is always exactly one-hot; no reachable state has act=0.

Optional Feature:
- Macro: MPX_PRIORITY_EN.
- Defined:
  - Multi-hot sel in manual mode resolves to the lowest set bit. act gets that single bit, dout gets that channel, sel_err<=0.
  - Only sel=0 is illegal: hold and sel_err<=1.
- Undefined: any multi-hot sel is illegal, as in Behaviour.

Test Plan (CH=4, W=16, SCAN_DIV=4; din ch0..3 = 16'h0001, 16'h0002, 16'h0003, 16'h0004 unless stated):
1. Reset then manual sweep. Assert rst_n=0 mid-cycle: dout=0, act=4'b0001 immediately. Release, en=1, mode=0, sel=0001,0010,0100,1000 on successive cycles: dout=1,2,3,4 each one cycle after sel; sel_err=0 throughout.
2. Illegal select. After sel=0100 (dout=3), apply sel=0000 then sel=0110: dout stays 3, act stays 0100, sel_err=1 on both following cycles. With MPX_PRIORITY_EN, sel=0110 gives dout=2, act=0010, sel_err=0.
3. Auto-scan wrap. mode 0->1, run 20 cycles:
   - act=0001 on the entry cycle, then 0010, 0100, 1000, 0001 at 4-cycle intervals.
   - scan_tick pulses exactly 4 times, each 1 cycle wide.
   - dout sequence is 1,2,3,4,1 lagging act by one cycle.
4. Enable freeze. In auto mode at prescaler=2, hold en=0 for 10 cycles: act, dout and scan_tick hold (scan_tick=0). After en=1, rotation occurs exactly 2 cycles later.
5. Live data and mode exit. In auto mode on ch1, change din ch1 to 16'hBEEF: dout=16'hBEEF next cycle. Switch mode=0 with sel=1000: dout=4, act=1000, prescaler=0.
6. Reset mid-scan. During auto mode on ch2, pulse rst_n low for 3 ns off-edge: outputs reset at once. After release with mode=1, scan restarts at act=0001 and the first scan_tick occurs 4 cycles later.
